ifetch_dual: RTL
================

# ifetch_dual

Dual-issue instruction fetch stage. Each cycle it presents an instruction pair (slot 1 at `IFpc1`, slot 2 at `IFpc1+4`) to the pre-register-read decode stage. It steers the next fetch address from the decode stage's control outputs: stall, intra-pair dependency, predicted branch, and mispredict `fail`. It tolerates variable-latency instruction memory and holds a pending redirect across memory wait cycles.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  byte address of slot-1 word; bits [1:0] always 0.
- `imem_rvalid`  in  1  data for the outstanding request is valid this cycle.
- `imem_rdata1`, `imem_rdata2`  in  32  words at `imem_addr` and `imem_addr+4` of the outstanding request.
- `ir1`, `ir2`  out  32  instructions to decode.
- `IFpc1`, `IFpc2`  out  32  PCs of `ir1`/`ir2`.
- `is_jump1`, `is_jump2`  out  1  slot holds a valid JAL, JALR or BRANCH opcode.
- `is_stall`, `depend`, `pre_branch1`, `pre_branch2`  in  1  decode-stage control for the current pair.
- `predict_pc1`, `predict_pc2`  in  32  predicted targets.
- `fail`  in  1  execute-stage mispredict.
- `fail_pc`  in  32  corrected PC.

## Operation
- **State `BOOT`**
  - Entered while `rst`=0.
  - First cycle after release: `imem_req`=1, `imem_addr`=`RESET_PC`, `req_pc`←`RESET_PC`, go to `FETCH`.
- **State `FETCH`**
  - `imem_req`=1.
  - Pair valid iff `imem_rvalid`=1. When valid: `ir1`/`ir2` come from `imem_rdata1`/`imem_rdata2`, `IFpc1`=`req_pc`, `IFpc2`=`req_pc+4`.
  - When valid, `next_pc` is chosen by priority:
    1. `fail`: `fail_pc`.
    2. `is_stall`: `req_pc` (re-present the same pair).
    3. `pre_branch1`: `predict_pc1` (slot 2 dropped).
    4. `depend`: `req_pc+4` (slot 2 becomes next slot 1).
    5. `pre_branch2`: `predict_pc2`.
    6. Otherwise: `req_pc+8`.
  - When valid: `imem_addr`=`next_pc`, `req_pc`←`next_pc`.
  - When not valid: `ir1`=`ir2`=NOP (32'h0000_0013), `IFpc1`=`IFpc2`=0, `is_jump*`=0, `imem_addr`=`req_pc` (held), and decode inputs are ignored. If `fail` is asserted in this case: `pend_pc`←`fail_pc`, go to `REDIR`.
- **State `REDIR`**
  - Outputs are NOP/0 regardless of `imem_rvalid`, and `imem_addr`=`req_pc` is held.
  - A new `fail` overwrites `pend_pc` (latest wins).
  - On `imem_rvalid`=1: response discarded, `imem_addr`=`pend_pc`, `req_pc`←`pend_pc`, go to `FETCH`.
  - `fail` and `imem_rvalid` in the same `REDIR` cycle: the new `fail_pc` is issued directly.
- **Arithmetic**
  - All PC arithmetic is 32-bit modulo 2^32: `req_pc+8` at 32'hFFFF_FFF8 wraps to 0.
  - Bits [1:0] of `fail_pc` and `predict_pc*` are forced to 0.
- **Outputs**
  - `is_jumpN` = pair valid AND `irN[6:0]` ∈ {1101111, 1100111, 1100011}.
- **Reset mid-operation**
  - Abandons any outstanding request and pending redirect; returns to `BOOT`.

## Timing
- Reset values, held while `rst`=0:
  - `imem_req`=0, `imem_addr`=0.
  - `ir1`=`ir2`=NOP, `IFpc1`=`IFpc2`=0, `is_jump*`=0.
  - `req_pc`=`RESET_PC`, `pend_pc`=0, state `BOOT`.
- `imem_addr` is combinational from decode controls (same-cycle path). All other outputs are combinational from `state`, `req_pc` and the memory response.
- Only registers: `state`, `req_pc`, `pend_pc`.
- Throughput: one pair per cycle with single-cycle memory. A request made in cycle t is presented in the first cycle t+k (k≥1) with `imem_rvalid`=1.
- Redirect penalty: none in `FETCH` with `rvalid`; in `REDIR`, one response is discarded.
- Exactly one request is outstanding at all times after `BOOT`.

## Structure
- `define.vh` holds the opcode constants (JAL, JALR, BRANCH), the NOP encoding and the state encodings.
- One combinational sub-module, `fetch_next_pc`, implements the priority mux and the +4/+8 adders.
- The FSM and registers stay in `ifetch_dual`.

## Test plan
- **Reset**: release `rst`, memory latency 1, `RESET_PC`=0x100 → `imem_addr`=0x100 in cycle 1. Cycle 2: `IFpc1`=0x100, `IFpc2`=0x104, `imem_addr`=0x108.
- **Stall and depend**: `is_stall` at `IFpc1`=0x200 → next `IFpc1`=0x200. Then `depend` → next `IFpc1`=0x204.
- **Predicted branches**:
  - `pre_branch1` with `predict_pc1`=0x400 together with `depend` → next `IFpc1`=0x400.
  - `pre_branch2` with `predict_pc2`=0x500 and no `depend` → next `IFpc1`=0x500.
- **Fail priority**: `fail` with `fail_pc`=0x800 together with `is_stall` and `pre_branch1` → next `IFpc1`=0x800.
- **Fail during wait**: `imem_rvalid`=0 for 3 cycles; `fail` with 0x900, then `fail` with 0xA00 during the wait. Required response:
  - Outputs NOP throughout.
  - On `rvalid`, the data is discarded and `imem_addr`=0xA00.
  - The next valid pair has `IFpc1`=0xA00.
- **Wrap and async reset**:
  - `req_pc`=0xFFFF_FFF8 with no controls → `imem_addr`=0.
  - `rst` asserted mid-wait → outputs go to their reset values immediately, then `BOOT`.

Source files
------------

// File: rtl/ifetch_dual_pkg.sv
// Shared definitions for the dual-issue fetch stage.
// Holds the FSM state encoding, the control-flow opcodes used for the is_jump
// flags, the NOP encoding and the PC alignment mask.
package ifetch_dual_pkg;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StFetch = 2'd1,
        StRedir = 2'd2
    } state_e;

    localparam logic [6:0]  OpJal       = 7'b1101111;
    localparam logic [6:0]  OpJalr      = 7'b1100111;
    localparam logic [6:0]  OpBranch    = 7'b1100011;
    localparam logic [31:0] InsnNop     = 32'h0000_0013;
    localparam logic [31:0] PcAlignMask = 32'hFFFF_FFFC;

    function automatic logic is_jump_op(input logic [31:0] insn);
        return (insn[6:0] == OpJal) || (insn[6:0] == OpJalr) || (insn[6:0] == OpBranch);
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-fetch-address selection for a valid instruction pair.
// Ports:
//   req_pc_i                 PC of slot 1 of the current pair
//   fail_i / fail_pc_i       execute-stage mispredict and corrected PC
//   is_stall_i, depend_i     decode hold / intra-pair dependency
//   pre_branch{1,2}_i        predicted-taken branch in slot 1 / slot 2
//   predict_pc{1,2}_i        predicted targets
//   next_pc_o                word-aligned next slot-1 address
module fetch_next_pc
    import ifetch_dual_pkg::*;
(
    input  logic [31:0] req_pc_i,
    input  logic        fail_i,
    input  logic [31:0] fail_pc_i,
    input  logic        is_stall_i,
    input  logic        depend_i,
    input  logic        pre_branch1_i,
    input  logic [31:0] predict_pc1_i,
    input  logic        pre_branch2_i,
    input  logic [31:0] predict_pc2_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;

    // Modulo-2^32 adders: wrap past the top of the address space is intended.
    assign pc_plus4 = req_pc_i + 32'd4;
    assign pc_plus8 = req_pc_i + 32'd8;

    always_comb begin
        next_pc_o = pc_plus8;
        if (fail_i) begin
            next_pc_o = fail_pc_i & PcAlignMask;
        end else if (is_stall_i) begin
            next_pc_o = req_pc_i;
        end else if (pre_branch1_i) begin
            // Slot 2 is on the not-taken path and is dropped.
            next_pc_o = predict_pc1_i & PcAlignMask;
        end else if (depend_i) begin
            // Slot 2 could not issue with slot 1; refetch it as the next slot 1.
            next_pc_o = pc_plus4;
        end else if (pre_branch2_i) begin
            next_pc_o = predict_pc2_i & PcAlignMask;
        end
    end

endmodule

// File: rtl/ifetch_dual.sv
// Dual-issue instruction fetch stage.
// Presents a pair (slot 1 at IFpc1, slot 2 at IFpc1+4) to decode each cycle the
// memory returns data, and steers the next request from decode/execute control.
// Exactly one memory request is outstanding after boot; imem_addr in a cycle
// with imem_rvalid=1 (or the boot cycle) is the new request, otherwise it holds
// the outstanding address. A mispredict seen while waiting on memory is parked
// in pend_pc and issued once the stale response arrives.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   imem_req/imem_addr       fetch request and slot-1 byte address
//   imem_rvalid/imem_rdata*  response for the outstanding request
//   ir1/ir2, IFpc1/IFpc2     pair and PCs to decode (NOP/0 when not valid)
//   is_jump1/is_jump2        slot holds JAL, JALR or BRANCH
//   is_stall, depend, pre_branch*, predict_pc*  decode control
//   fail, fail_pc            execute-stage mispredict redirect
module ifetch_dual
    import ifetch_dual_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata1,
    input  logic [31:0] imem_rdata2,
    output logic [31:0] ir1,
    output logic [31:0] ir2,
    output logic [31:0] IFpc1,
    output logic [31:0] IFpc2,
    output logic        is_jump1,
    output logic        is_jump2,
    input  logic        is_stall,
    input  logic        depend,
    input  logic        pre_branch1,
    input  logic        pre_branch2,
    input  logic [31:0] predict_pc1,
    input  logic [31:0] predict_pc2,
    input  logic        fail,
    input  logic [31:0] fail_pc
);

    state_e      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] next_pc;
    logic [31:0] fail_pc_aligned;
    logic        pair_valid;

    assign fail_pc_aligned = fail_pc & PcAlignMask;

    fetch_next_pc u_next_pc (
        .req_pc_i      (req_pc_q),
        .fail_i        (fail),
        .fail_pc_i     (fail_pc),
        .is_stall_i    (is_stall),
        .depend_i      (depend),
        .pre_branch1_i (pre_branch1),
        .predict_pc1_i (predict_pc1),
        .pre_branch2_i (pre_branch2),
        .predict_pc2_i (predict_pc2),
        .next_pc_o     (next_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StBoot;
            req_pc_q  <= RESET_PC;
            pend_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            req_pc_q  <= req_pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        pend_pc_d  = pend_pc_q;
        imem_req   = 1'b0;
        imem_addr  = 32'h0;
        pair_valid = 1'b0;

        unique case (state_q)
            StBoot: begin
                imem_req  = 1'b1;
                imem_addr = RESET_PC;
                req_pc_d  = RESET_PC;
                state_d   = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_rvalid) begin
                    pair_valid = 1'b1;
                    imem_addr  = next_pc;
                    req_pc_d   = next_pc;
                end else begin
                    imem_addr = req_pc_q;
                    if (fail) begin
                        pend_pc_d = fail_pc_aligned;
                        state_d   = StRedir;
                    end
                end
            end
            StRedir: begin
                imem_req  = 1'b1;
                imem_addr = req_pc_q;
                if (fail) begin
                    pend_pc_d = fail_pc_aligned;
                end
                if (imem_rvalid) begin
                    // Stale response is dropped; a same-cycle fail beats the parked one.
                    imem_addr = fail ? fail_pc_aligned : pend_pc_q;
                    req_pc_d  = imem_addr;
                    state_d   = StFetch;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        // Outputs take their reset values as soon as rst falls, not at the next edge.
        if (!rst) begin
            imem_req   = 1'b0;
            imem_addr  = 32'h0;
            pair_valid = 1'b0;
        end
    end

    always_comb begin
        ir1      = pair_valid ? imem_rdata1 : InsnNop;
        ir2      = pair_valid ? imem_rdata2 : InsnNop;
        IFpc1    = pair_valid ? req_pc_q : 32'h0;
        IFpc2    = pair_valid ? (req_pc_q + 32'd4) : 32'h0;
        is_jump1 = pair_valid && is_jump_op(imem_rdata1);
        is_jump2 = pair_valid && is_jump_op(imem_rdata2);
    end

endmodule
